banked_mem_rw_helper: RTL
=========================

BANKED_MEM_RW_HELPER -- requirements
Module: banked_mem_rw_helper

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the word width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter BANK_NUM, default 4, SHALL set the number of banks, in the range 1..8.
REQ-004 Parameter BANK_ADDR_BITS, default 27, SHALL set the words per bank to 2^BANK_ADDR_BITS.
REQ-005 Parameter READ_LATENCY, default 1, SHALL set the read request-to-response cycles, in the range 1..4.
REQ-006 Port clock, input, width 1, SHALL be the sole clock; every flop SHALL update on its rising edge.
REQ-007 Port reset, input, width 1, SHALL be the synchronous active-high reset.
REQ-008 Port enable, input, width 1, SHALL be the global qualifier; when low, requests SHALL be ignored and the pipeline SHALL keep advancing.
REQ-009 Port r_valid, input, width 1, SHALL be the read request.
REQ-010 Port r_index, input, width 64, SHALL be the read word index.
REQ-011 Port r_resp_valid, output, width 1, SHALL signal that the read response is valid.
REQ-012 Port r_data, output, width DATA_WIDTH, SHALL carry the read data.
REQ-013 Port r_err, output, width 1, SHALL flag an out-of-range read, qualified by r_resp_valid.
REQ-014 Port w_valid, input, width 1, SHALL be the write request.
REQ-015 Port w_index, input, width 64, SHALL be the write word index.
REQ-016 Port w_data, input, width DATA_WIDTH, SHALL carry the write data.
REQ-017 Port w_mask, input, width DATA_WIDTH, SHALL be the bit-granular write mask.
REQ-018 Port w_err, output, width 1, SHALL pulse one cycle after an out-of-range write.
REQ-019 Port err_count, output, width 16, SHALL hold the saturating count of out-of-range accesses.

Function
REQ-020 Bank select SHALL be index[BANK_ADDR_BITS +: 3], and the word offset SHALL be index[BANK_ADDR_BITS-1:0].
- Bits above BANK_ADDR_BITS+2 SHALL be ignored.
REQ-021 An access SHALL be out-of-range when the bank select is greater than or equal to BANK_NUM.
- An out-of-range access SHALL NOT use $fatal; it SHALL be reported through r_err, w_err and err_count.
REQ-022 A read SHALL be accepted when r_valid and enable are both high on a rising edge.
- r_resp_valid SHALL be high exactly READ_LATENCY cycles later, for one cycle.
REQ-023 Reads SHALL be fully pipelined: one accepted read per cycle; responses SHALL return in order with no backpressure.
REQ-024 An in-range read SHALL return the stored word in r_data with r_err=0.
- An out-of-range read SHALL return r_data=0 with r_err=1.
REQ-025 A write SHALL be accepted when w_valid and enable are both high.
- An in-range write SHALL set the word to (w_data & w_mask) | (old & ~w_mask) at that edge.
- An out-of-range write SHALL leave memory unchanged and pulse w_err on the next cycle.
REQ-026 A read and a write to the same index in the same cycle SHALL be read-first: the read SHALL return the pre-write value.
REQ-027 A read accepted one or more cycles after a write SHALL observe the written value, for any READ_LATENCY.
REQ-028 err_count SHALL add 1 for each out-of-range read and 1 for each out-of-range write.
- When both occur in the same cycle, it SHALL add 2.
- It SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 Outside a response cycle, r_data and r_err SHALL hold their last values.
REQ-030 w_mask=0 SHALL be a legal write with no effect on memory; it SHALL still be counted if out-of-range.

Reset
REQ-031 While reset is high, the read pipeline valid bits SHALL clear.
- r_resp_valid, r_err, w_err, r_data and err_count SHALL all be 0 on the cycle after reset is sampled high.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reads in flight when reset is asserted SHALL be discarded and never responded to.
REQ-034 Requests presented while reset is high SHALL be ignored.

Verification
REQ-035 READ_LATENCY=3: write index 5 = 64'hDEAD_BEEF_0000_1111 with full mask, then read index 5 -> r_resp_valid exactly 3 cycles after the read with r_data=64'hDEAD_BEEF_0000_1111 and r_err=0.
REQ-036 Masked write: word = 64'hFFFF_FFFF_FFFF_FFFF, then write w_data=0 with w_mask=64'h0000_0000_FFFF_0000 -> read returns 64'hFFFF_FFFF_0000_FFFF.
REQ-037 BANK_NUM=4, BANK_ADDR_BITS=27: read index 64'h2000_0000 (bank 4) -> r_data=0, r_err=1, err_count=1.
- Then write the same index -> w_err pulses one cycle later, err_count=2, and bank 0 word 0 is unchanged.
REQ-038 Same-cycle read and write to index 7 (old value 1, new value 2) -> the read returns 1; the next read returns 2.
- Back-to-back reads on 4 consecutive cycles -> 4 in-order responses on consecutive cycles.
REQ-039 Issue 2 reads with READ_LATENCY=4 and assert reset for 1 cycle mid-flight -> no r_resp_valid for those reads, err_count=0, and previously written data is still readable.
REQ-040 Preload err_count to 16'hFFFE via repeated errors, then issue a same-cycle out-of-range read and write -> err_count=16'hFFFF and it stays there.

Source files
------------

// File: rtl/banked_mem_rw_helper.sv
// Banked word memory with a fixed-latency read pipeline, bit-masked writes and
// out-of-range reporting through r_err, w_err and a saturating error counter.
module banked_mem_rw_helper #(
    parameter int DATA_WIDTH     = 64,
    parameter int BANK_NUM       = 4,
    parameter int BANK_ADDR_BITS = 27,
    parameter int READ_LATENCY   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  r_valid,
    input  logic [63:0]           r_index,
    output logic                  r_resp_valid,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_err,
    input  logic                  w_valid,
    input  logic [63:0]           w_index,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] w_mask,
    output logic                  w_err,
    output logic [15:0]           err_count
);

    localparam int          WORDS      = 2 ** BANK_ADDR_BITS;
    localparam int          BSEL_W     = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam logic [3:0]  BANK_NUM_W = 4'(BANK_NUM);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (BANK_NUM < 1 || BANK_NUM > 8) begin : g_bad_banks
        $error("BANK_NUM must be in 1..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..4");
    end

    function automatic logic [DATA_WIDTH-1:0] merge_mask(
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] mask
    );
        return (new_word & mask) | (old_word & ~mask);
    endfunction

    function automatic logic [15:0] sat_add(
        input logic [15:0] cnt,
        input logic [1:0]  inc
    );
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [BANK_NUM][WORDS];

    logic [2:0]                w_rd_bank;
    logic [2:0]                w_wr_bank;
    logic [BANK_ADDR_BITS-1:0] w_rd_off;
    logic [BANK_ADDR_BITS-1:0] w_wr_off;
    logic                      w_rd_oor;
    logic                      w_wr_oor;
    logic                      w_rd_acc;
    logic                      w_wr_acc;
    logic [DATA_WIDTH-1:0]     w_rd_word;
    logic [DATA_WIDTH-1:0]     w_wr_old;
    logic [1:0]                w_err_inc;
    logic                      w_unused;

    // Index bits above the bank select carry no meaning here.
    assign w_unused  = ^{r_index[63:BANK_ADDR_BITS+3], w_index[63:BANK_ADDR_BITS+3]};

    assign w_rd_bank = r_index[BANK_ADDR_BITS +: 3];
    assign w_wr_bank = w_index[BANK_ADDR_BITS +: 3];
    assign w_rd_off  = r_index[BANK_ADDR_BITS-1:0];
    assign w_wr_off  = w_index[BANK_ADDR_BITS-1:0];
    assign w_rd_oor  = ({1'b0, w_rd_bank} >= BANK_NUM_W);
    assign w_wr_oor  = ({1'b0, w_wr_bank} >= BANK_NUM_W);

    assign w_rd_acc  = r_valid & enable & ~reset;
    assign w_wr_acc  = w_valid & enable & ~reset;
    assign w_err_inc = {1'b0, w_rd_acc & w_rd_oor} + {1'b0, w_wr_acc & w_wr_oor};

    // The memory is sampled at the accepting edge, before any same-edge write lands.
    assign w_rd_word = w_rd_oor ? '0 : r_mem[w_rd_bank[BSEL_W-1:0]][w_rd_off];
    assign w_wr_old  = r_mem[w_wr_bank[BSEL_W-1:0]][w_wr_off];

    always_ff @(posedge clock) begin
        if (w_wr_acc && !w_wr_oor) begin
            r_mem[w_wr_bank[BSEL_W-1:0]][w_wr_off] <= merge_mask(w_data, w_wr_old, w_mask);
        end
    end

    // ---- read pipeline: stage p[0] captures at accept, p[READ_LATENCY-1] drives outputs
    logic                  r_vld_p  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_word_p [READ_LATENCY];
    logic                  r_oor_p  [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_vld_p[k] <= 1'b0;
            end
        end else begin
            r_vld_p[0] <= w_rd_acc;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
            end
        end
    end

    // Data moves only with a valid beat, so the output stage holds between responses.
    always_ff @(posedge clock) begin
        if (w_rd_acc) begin
            r_word_p[0] <= w_rd_word;
            r_oor_p[0]  <= w_rd_oor;
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
            if (r_vld_p[k-1]) begin
                r_word_p[k] <= r_word_p[k-1];
                r_oor_p[k]  <= r_oor_p[k-1];
            end
        end
        if (reset) begin
            r_word_p[READ_LATENCY-1] <= '0;
            r_oor_p[READ_LATENCY-1]  <= 1'b0;
        end
    end

    // ---- error reporting
    logic        r_werr_p0;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_werr_p0 <= 1'b0;
            r_err_cnt <= 16'd0;
        end else begin
            r_werr_p0 <= w_wr_acc & w_wr_oor;
            r_err_cnt <= sat_add(r_err_cnt, w_err_inc);
        end
    end

    assign r_resp_valid = r_vld_p[READ_LATENCY-1];
    assign r_data       = r_word_p[READ_LATENCY-1];
    assign r_err        = r_oor_p[READ_LATENCY-1];
    assign w_err        = r_werr_p0;
    assign err_count    = r_err_cnt;

endmodule
